// File: rtl/vid_addr_gen_pkg.sv
// Shared definitions for the video address generator: CPU byte-lane selects
// and the shadow-register state machine encoding.
package vid_addr_gen_pkg;

  localparam logic [1:0] SEL_LO   = 2'd0;
  localparam logic [1:0] SEL_MID  = 2'd1;
  localparam logic [1:0] SEL_HI   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic {
    IDLE,
    STAGED
  } state_t;

endpackage

// File: rtl/vid_addr_shadow.sv
// CPU write staging for the video counter: byte-lane shadow, dirty mask and
// commit timing, producing the merged counter value applied at commit.
module vid_addr_shadow
  import vid_addr_gen_pkg::*;
#(
  parameter int AW = 21
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          line_end,
  input  logic          display,
  input  logic          cpu_wr,
  input  logic [1:0]    cpu_sel,
  input  logic [7:0]    cpu_din,
  input  logic [AW-1:0] vid,
  output logic          commit,
  output logic [AW-1:0] merged,
  output logic          pending
);

  state_t        state;
  logic [AW-1:0] shd;
  logic [AW-1:0] lane_mask;
  logic [2:0]    dirty;

  assign pending = (state == STAGED);

  // Outside the display window a staged write lands at once; inside it waits
  // for the line boundary so the fetch sequence never sees a torn address.
  assign commit = pending && (!display || line_end);

  always_comb begin
    lane_mask = '0;
    if (dirty[0]) lane_mask[7:0]     = '1;
    if (dirty[1]) lane_mask[15:8]    = '1;
    if (dirty[2]) lane_mask[AW-1:16] = '1;
  end

  assign merged = (shd & lane_mask) | (vid & ~lane_mask);

  // A write arriving with a clear (commit or frame start) lands after it,
  // so the later non-blocking assignments deliberately override the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shd   <= '0;
      dirty <= '0;
    end else begin
      if (frame_start || commit) begin
        dirty <= '0;
        state <= IDLE;
      end
      if (cpu_wr) begin
        case (cpu_sel)
          SEL_LO: begin
            shd[7:0] <= cpu_din;
            dirty[0] <= 1'b1;
            state    <= STAGED;
          end
          SEL_MID: begin
            shd[15:8] <= cpu_din;
            dirty[1]  <= 1'b1;
            state     <= STAGED;
          end
          SEL_HI: begin
            shd[AW-1:16] <= cpu_din[AW-17:0];
            dirty[2]     <= 1'b1;
            state        <= STAGED;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/vid_addr_gen.sv
// Video word-address counter: frame base load, per-fetch increment,
// end-of-line offset skip and atomic CPU reprogramming via the shadow stage.
module vid_addr_gen
  import vid_addr_gen_pkg::*;
#(
  parameter int AW = 21,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic [AW-1:0] base,
  input  logic          fetch,
  input  logic          line_end,
  input  logic [LW-1:0] line_off,
  input  logic          display,
  input  logic          cpu_wr,
  input  logic [1:0]    cpu_sel,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] vid,
  output logic          pending
);

  logic          commit;
  logic [AW-1:0] merged;
  logic [7:0]    hi_byte;

  vid_addr_shadow #(.AW(AW)) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .line_end   (line_end),
    .display    (display),
    .cpu_wr     (cpu_wr),
    .cpu_sel    (cpu_sel),
    .cpu_din    (cpu_din),
    .vid        (vid),
    .commit     (commit),
    .merged     (merged),
    .pending    (pending)
  );

  // A commit replaces the whole step, so fetch and line offset are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid <= '0;
    end else if (frame_start) begin
      vid <= base;
    end else if (commit) begin
      vid <= merged;
    end else begin
      vid <= vid + AW'(fetch) + (line_end ? AW'(line_off) : '0);
    end
  end

  always_comb begin
    hi_byte          = '0;
    hi_byte[AW-17:0] = vid[AW-1:16];
    case (cpu_sel)
      SEL_LO:  cpu_dout = vid[7:0];
      SEL_MID: cpu_dout = vid[15:8];
      SEL_HI:  cpu_dout = hi_byte;
      default: cpu_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_vid_addr_gen.sv
// Directed bench for vid_addr_gen: AW=21 main instance plus an AW=24 instance
// for the full-width high lane.
module tb_vid_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [20:0] base;
  logic [23:0] base24;
  logic        fetch;
  logic        line_end;
  logic [7:0]  line_off;
  logic        display;
  logic        cpu_wr;
  logic [1:0]  cpu_sel;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_dout24;
  logic [20:0] vid;
  logic [23:0] vid24;
  logic        pending;
  logic        pending24;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vid_addr_gen #(.AW(21), .LW(8)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .base(base),
    .fetch(fetch), .line_end(line_end), .line_off(line_off), .display(display),
    .cpu_wr(cpu_wr), .cpu_sel(cpu_sel), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .vid(vid), .pending(pending)
  );

  vid_addr_gen #(.AW(24), .LW(8)) dut24 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .base(base24),
    .fetch(fetch), .line_end(line_end), .line_off(line_off), .display(display),
    .cpu_wr(cpu_wr), .cpu_sel(cpu_sel), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout24), .vid(vid24), .pending(pending24)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic fs, input logic [20:0] b,
                                input logic f, input logic le);
    frame_start = fs;
    base        = b;
    fetch       = f;
    line_end    = le;
  endtask

  task automatic cpu_write(input logic [1:0] sel, input logic [7:0] din);
    cpu_wr  = 1'b1;
    cpu_sel = sel;
    cpu_din = din;
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    base24 = '0; line_off = '0; display = 1'b0;
    cpu_wr = 1'b0; cpu_sel = 2'd0; cpu_din = '0;
    #3;
    check_output("reset_vid", 32'(vid), 32'h0);
    check_output("reset_pending", 32'(pending), 32'h0);
    check_output("reset_dout", 32'(cpu_dout), 32'h0);
    tick(2);
    reset = 1'b0;
    tick();

    // Frame base load then 80 fetches
    apply_stimulus(1'b1, 21'h07_8000, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("frame_load", 32'(vid), 32'h07_8000);
    fetch = 1'b1;
    tick(80);
    fetch = 1'b0;
    check_output("fetch80", 32'(vid), 32'h07_8050);
    check_output("fetch80_pending", 32'(pending), 32'h0);
    cpu_sel = 2'd0; #1; check_output("dout_lo", 32'(cpu_dout), 32'h50);
    cpu_sel = 2'd1; #1; check_output("dout_mid", 32'(cpu_dout), 32'h80);
    cpu_sel = 2'd2; #1; check_output("dout_hi", 32'(cpu_dout), 32'h07);
    cpu_sel = 2'd3; #1; check_output("dout_none", 32'(cpu_dout), 32'h0);

    // Line offset together with fetch
    apply_stimulus(1'b1, 21'h100, 1'b0, 1'b0);
    tick();
    line_off = 8'h10;
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("line_off_fetch", 32'(vid), 32'h111);
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    check_output("line_off_only", 32'(vid), 32'h121);

    // Write during display waits for line end
    apply_stimulus(1'b1, 21'h12_3456, 1'b0, 1'b0);
    display = 1'b1;
    tick();
    frame_start = 1'b0;
    cpu_write(2'd1, 8'hAB);
    tick();
    cpu_wr = 1'b0;
    check_output("disp_pending", 32'(pending), 32'h1);
    check_output("disp_hold", 32'(vid), 32'h12_3456);
    fetch = 1'b1;
    tick(2);
    check_output("disp_counting", 32'(vid), 32'h12_3458);
    check_output("disp_still_pending", 32'(pending), 32'h1);
    line_end = 1'b1;
    tick();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("line_end_commit", 32'(vid), 32'h12_AB58);
    check_output("line_end_pending", 32'(pending), 32'h0);

    // Blanking write, plus a write landing in the commit cycle
    display = 1'b0;
    cpu_write(2'd0, 8'h55);
    tick();
    check_output("blank_staged", 32'(pending), 32'h1);
    check_output("blank_not_yet", 32'(vid), 32'h12_AB58);
    cpu_write(2'd2, 8'h0F);
    tick();
    cpu_wr = 1'b0;
    check_output("blank_commit", 32'(vid), 32'h12_AB55);
    check_output("commit_cycle_write_pending", 32'(pending), 32'h1);
    tick();
    check_output("second_commit", 32'(vid), 32'h0F_AB55);
    check_output("second_commit_pending", 32'(pending), 32'h0);

    // Wrap at all-ones
    apply_stimulus(1'b1, 21'h1F_FFFF, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    fetch = 1'b0;
    check_output("wrap", 32'(vid), 32'h0);

    // Frame start discards a staged write
    display = 1'b1;
    cpu_write(2'd0, 8'h77);
    tick();
    cpu_wr = 1'b0;
    check_output("staged_before_fs", 32'(pending), 32'h1);
    apply_stimulus(1'b1, 21'h1000, 1'b0, 1'b0);
    tick();
    frame_start = 1'b0;
    display = 1'b0;
    check_output("fs_discard_vid", 32'(vid), 32'h1000);
    check_output("fs_discard_pending", 32'(pending), 32'h0);
    tick();
    check_output("fs_no_stale_commit", 32'(vid), 32'h1000);

    // Write in the frame_start cycle is kept
    apply_stimulus(1'b1, 21'h2000, 1'b0, 1'b0);
    cpu_write(2'd0, 8'h34);
    tick();
    frame_start = 1'b0;
    cpu_wr = 1'b0;
    check_output("fs_wr_vid", 32'(vid), 32'h2000);
    check_output("fs_wr_pending", 32'(pending), 32'h1);
    tick();
    check_output("fs_wr_commit", 32'(vid), 32'h2034);

    // Async reset mid-line while staged
    display = 1'b1;
    cpu_write(2'd1, 8'h99);
    tick();
    cpu_wr = 1'b0;
    fetch = 1'b1;
    tick();
    check_output("pre_reset_pending", 32'(pending), 32'h1);
    #2 reset = 1'b1;
    cpu_sel = 2'd0;
    #1;
    check_output("async_reset_vid", 32'(vid), 32'h0);
    check_output("async_reset_pending", 32'(pending), 32'h0);
    check_output("async_reset_dout", 32'(cpu_dout), 32'h0);
    fetch = 1'b0;
    display = 1'b0;
    tick();
    reset = 1'b0;
    tick(2);
    check_output("post_reset_vid", 32'(vid), 32'h0);
    check_output("post_reset_pending", 32'(pending), 32'h0);

    // High lane: 5 bits at AW=21, full byte at AW=24
    cpu_write(2'd2, 8'hFF);
    tick();
    cpu_wr = 1'b0;
    tick();
    check_output("hi_lane_aw24", 32'(vid24), 32'hFF_0000);
    check_output("hi_lane_aw21", 32'(vid), 32'h1F_0000);
    cpu_sel = 2'd2; #1;
    check_output("hi_dout_aw24", 32'(cpu_dout24), 32'hFF);
    check_output("hi_dout_aw21", 32'(cpu_dout), 32'h1F);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
